// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 Hz VGA timing constants.
// Holds the default pixel divider and porch/sync widths, the derived line and
// frame totals, the sync window bounds, and the coordinate width. The timing
// generator and the downstream renderers (glyphs, paddles, ball) all use them.
package vga_timing_pkg;

  // Coordinate width for x/y. H_TOTAL and V_TOTAL must both fit in it.
  localparam int unsigned COORD_W = 10;

  // System clocks per pixel (100 MHz system clock, 25 MHz pixel clock).
  localparam int unsigned VGA_PIX_DIV = 4;

  // Horizontal timing, in pixels.
  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;

  // Vertical timing, in lines.
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  // Derived totals.
  localparam int unsigned VGA_H_TOTAL =
    VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Sync windows. The start is inclusive and the end is exclusive.
  localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Registered sync/blanking bundle driven alongside the coordinates.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input int unsigned       lo,
                                     input int unsigned       hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: enabled modulo-N up counter with a wrap strobe.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   en           : advance the count on this clock
//   count        : current count, 0..N-1 (registered)
//   wrap         : en && count == N-1, combinational, so it can chain counters
module mod_counter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count. With N == 1 the count stays 0 and wrap follows en.
  always_comb begin
    count_d = count_q;
    wrap    = en && (count_q == W'(N - 1));
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator for the pong display pipeline.
// It divides clk down to a pixel tick, steps the x/y raster counters, and
// registers hsync, vsync and video_on so that they track the current x/y.
// Ports:
//   clk, reset_n : system clock and asynchronous active-low reset
//   x, y         : current raster position (registered)
//   hsync, vsync : active-low sync pulses (registered)
//   video_on     : x/y are inside the visible area (registered)
//   p_tick       : one-clk pulse in the first clk of each new pixel
//   frame_tick   : one-clk pulse in the first clk of pixel (0,0)
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIX_DIV   = VGA_PIX_DIV,
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic               frame_tick
);

  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned DIV_W        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0]   div_cnt;
  logic               tick_en;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic               x_wrap;
  logic               y_wrap;
  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;

  sync_t sync_q;
  sync_t sync_d;
  logic  p_tick_q;
  logic  p_tick_d;
  logic  frame_tick_q;
  logic  frame_tick_d;

  // The divider count is read only through its wrap strobe.
  logic div_cnt_unused;
  assign div_cnt_unused = ^div_cnt;

  // Pixel divider: tick_en is high on the last clk of each pixel period.
  mod_counter #(
    .N (PIX_DIV),
    .W (DIV_W)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .count   (div_cnt),
    .wrap    (tick_en)
  );

  // Horizontal counter.
  mod_counter #(
    .N (H_TOTAL),
    .W (COORD_W)
  ) u_x (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tick_en),
    .count   (x_cnt),
    .wrap    (x_wrap)
  );

  // Vertical counter, advanced at the end of each line.
  mod_counter #(
    .N (V_TOTAL),
    .W (COORD_W)
  ) u_y (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (x_wrap),
    .count   (y_cnt),
    .wrap    (y_wrap)
  );

  // Position the counters move to on this tick. Only used when tick_en is high.
  always_comb begin
    x_nxt = x_cnt + COORD_W'(1);
    y_nxt = y_cnt;
    if (x_wrap) begin
      x_nxt = '0;
      y_nxt = y_wrap ? '0 : (y_cnt + COORD_W'(1));
    end
  end

  // Decode the next position so that the registered syncs line up with x/y.
  // The syncs hold between ticks, so video_on stays low after reset until
  // the first advance.
  always_comb begin
    sync_d       = sync_q;
    p_tick_d     = tick_en;
    frame_tick_d = y_wrap;
    if (tick_en) begin
      sync_d.hsync    = !in_window(x_nxt, H_SYNC_START, H_SYNC_END);
      sync_d.vsync    = !in_window(y_nxt, V_SYNC_START, V_SYNC_END);
      sync_d.video_on = (32'(x_nxt) < H_DISPLAY) && (32'(y_nxt) < V_DISPLAY);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};
      p_tick_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      p_tick_q     <= p_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign x          = x_cnt;
  assign y          = y_cnt;
  assign hsync      = sync_q.hsync;
  assign vsync      = sync_q.vsync;
  assign video_on   = sync_q.video_on;
  assign p_tick     = p_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: drives three vga_sync instances that share one clock and one
// reset. The instances are the default 640x480 timing, a tiny timing with
// PIX_DIV = 1, and a small timing with PIX_DIV = 3. Reset assertion times and
// run lengths are random. Each instance is compared every clock against an
// arithmetic model of the raster position, which is derived from the number
// of clock edges since reset was released.
module tb_vga_sync;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  logic [9:0] d_x, d_y;
  logic       d_hs, d_vs, d_vo, d_pt, d_ft;
  logic [9:0] s_x, s_y;
  logic       s_hs, s_vs, s_vo, s_pt, s_ft;
  logic [9:0] m_x, m_y;
  logic       m_hs, m_vs, m_vo, m_pt, m_ft;

  vga_sync u_dflt (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (d_x),
    .y          (d_y),
    .hsync      (d_hs),
    .vsync      (d_vs),
    .video_on   (d_vo),
    .p_tick     (d_pt),
    .frame_tick (d_ft)
  );

  vga_sync #(
    .PIX_DIV   (1),
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (2),
    .H_BACK    (2),
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (1),
    .V_BACK    (1)
  ) u_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (s_x),
    .y          (s_y),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .video_on   (s_vo),
    .p_tick     (s_pt),
    .frame_tick (s_ft)
  );

  vga_sync #(
    .PIX_DIV   (3),
    .H_DISPLAY (10),
    .H_FRONT   (3),
    .H_SYNC    (4),
    .H_BACK    (2),
    .V_DISPLAY (5),
    .V_FRONT   (2),
    .V_SYNC    (1),
    .V_BACK    (2)
  ) u_mid (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (m_x),
    .y          (m_y),
    .hsync      (m_hs),
    .vsync      (m_vs),
    .video_on   (m_vo),
    .p_tick     (m_pt),
    .frame_tick (m_ft)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned n_edges  = 0;  // rising edges seen with reset released

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: n clock edges after release give k = n / p pixel advances,
  // and the raster position follows from k.
  task automatic check_dut(input string name, input int unsigned n, input int unsigned p,
                           input int unsigned hd, input int unsigned hf,
                           input int unsigned hs, input int unsigned hb,
                           input int unsigned vd, input int unsigned vf,
                           input int unsigned vs, input int unsigned vb,
                           input logic [9:0] gx, input logic [9:0] gy,
                           input logic ghs, input logic gvs, input logic gvo,
                           input logic gpt, input logic gft);
    int unsigned ht, vt, k, ex, ey;
    logic        ept, eft, evo, ehs, evs;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    k   = n / p;
    ex  = k % ht;
    ey  = (k / ht) % vt;
    ept = (n > 0) && (n % p == 0);
    eft = ept && (k % (ht * vt) == 0);
    evo = (k > 0) && (ex < hd) && (ey < vd);
    ehs = !((ex >= hd + hf) && (ex < hd + hf + hs));
    evs = !((ey >= vd + vf) && (ey < vd + vf + vs));
    check($sformatf("%s.x", name), 32'(gx), ex);
    check($sformatf("%s.y", name), 32'(gy), ey);
    check($sformatf("%s.hsync", name), 32'(ghs), 32'(ehs));
    check($sformatf("%s.vsync", name), 32'(gvs), 32'(evs));
    check($sformatf("%s.video_on", name), 32'(gvo), 32'(evo));
    check($sformatf("%s.p_tick", name), 32'(gpt), 32'(ept));
    check($sformatf("%s.frame_tick", name), 32'(gft), 32'(eft));
  endtask

  task automatic check_all();
    check_dut("dflt", n_edges, 4, 640, 16, 96, 48, 480, 10, 2, 33,
              d_x, d_y, d_hs, d_vs, d_vo, d_pt, d_ft);
    check_dut("small", n_edges, 1, 8, 2, 2, 2, 4, 1, 1, 1,
              s_x, s_y, s_hs, s_vs, s_vo, s_pt, s_ft);
    check_dut("mid", n_edges, 3, 10, 3, 4, 2, 5, 2, 1, 2,
              m_x, m_y, m_hs, m_vs, m_vo, m_pt, m_ft);
  endtask

  task automatic run(input int unsigned cycles);
    repeat (cycles) begin
      @(posedge clk);
      n_edges++;
      #1 check_all();
    end
  endtask

  // Drop reset between edges, check that the outputs clear before the next
  // edge, hold reset for a few clocks, then release away from an edge.
  task automatic async_reset();
    @(posedge clk);
    n_edges++;
    #1 check_all();
    #2 reset_n = 1'b0;
    n_edges = 0;
    #1 check_all();
    repeat ($urandom_range(1, 4)) begin
      @(posedge clk);
      #1 check_all();
    end
    #3 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all();
    @(posedge clk);
    #2 reset_n = 1'b1;
    // Longer than two default lines, so the 799 -> 0 wrap and the hsync
    // window are both seen.
    run(7000);
    for (int s = 0; s < 6; s++) begin
      async_reset();
      run($urandom_range(40, 3000));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
